fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arb_pkg.sv | 35 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_wr_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   localparam int unsigned STAT_W   = 16;
   // Widest requester vector the pick helper supports.
   localparam int unsigned PICK_MAX = 8;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   // Round-robin pick: scan last+1 .. last+n (mod n), first valid wins.
   function automatic pick_t rr_next(input logic [PICK_MAX-1:0] valid,
                                     input logic [2:0]          last,
                                     input int unsigned         n);
      pick_t       r;
      int unsigned k;
      r = '0;
      for (int unsigned off = 1; off <= PICK_MAX; off++) begin
         k = (32'(last) + off) % n;
         if ((off <= n) && !r.found && valid[k[2:0]]) begin
            r.found = 1'b1;
            r.idx   = k[2:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: the requester after 'last'
// (wrapping) with valid set wins; 'found' is low when nothing is valid.
module rr_pick
   import fifo_wr_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [ID_W-1:0]  last,
   output logic [ID_W-1:0]  idx,
   output logic             found
);

   logic [PICK_MAX-1:0] valid_ext;
   pick_t               pick;
   logic                unused_idx_bits;

   // Zero-extend the request vector to the helper's fixed width.
   always_comb begin
      valid_ext              = '0;
      valid_ext[N_REQ-1:0]   = valid;
   end

   assign pick            = rr_next(valid_ext, 3'(last), N_REQ);
   assign idx             = pick.idx[ID_W-1:0];
   assign found           = pick.found;
   assign unused_idx_bits = ^pick.idx;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side scheduler sharing one async-FIFO write port among N_REQ
// producers: round-robin with bounded bursts, registered arbitration,
// combinational data/handshake path.
// Optional per-requester transfer counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter  int unsigned N_REQ     = 4,
   parameter  int unsigned WIDTH     = 8,
   parameter  int unsigned MAX_BURST = 8,
   localparam int unsigned ID_W      = $clog2(N_REQ)
) (
   input  logic                   wclk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   input  logic                   wfull,
   output logic                   winc,
   output logic [WIDTH-1:0]       wdata,
   output logic                   grant_vld,
   output logic [ID_W-1:0]        grant_id
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   input  logic                   stats_clr,
   output logic [N_REQ*STAT_W-1:0] word_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t       state_q, state_d;
   logic             gvld_q, gvld_d;
   logic [ID_W-1:0]  gid_q, gid_d;
   logic [ID_W-1:0]  rr_last_q, rr_last_d;
   logic [CNT_W-1:0] burst_q, burst_d;

   logic [ID_W-1:0]  pick_last;
   logic [ID_W-1:0]  pick_idx;
   logic             pick_found;
   logic             cur_valid;
   logic             xfer_any;
   logic [N_REQ-1:0] xfer;

   // In GRANT the only pick that matters is the release re-pick, whose
   // priority base is the current holder (it becomes rr_last on release).
   assign pick_last = (state_q == ARB_GRANT) ? gid_q : rr_last_q;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .valid (req_valid),
      .last  (pick_last),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign cur_valid = req_valid[gid_q];
   assign xfer_any  = gvld_q & cur_valid & ~wfull;
   assign winc      = xfer_any;
   assign wdata     = req_data[32'(gid_q)*WIDTH +: WIDTH];
   assign grant_vld = gvld_q;
   assign grant_id  = gid_q;
   assign xfer      = req_valid & req_ready;

   // Ready goes only to the granted requester while the FIFO has room.
   always_comb begin
      req_ready = '0;
      if (gvld_q && !wfull) begin
         req_ready[gid_q] = 1'b1;
      end
   end

   // Arbitration state register.
   always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ARB_IDLE;
         gvld_q    <= 1'b0;
         gid_q     <= '0;
         rr_last_q <= ID_W'(N_REQ - 1);
         burst_q   <= '0;
      end else begin
         state_q   <= state_d;
         gvld_q    <= gvld_d;
         gid_q     <= gid_d;
         rr_last_q <= rr_last_d;
         burst_q   <= burst_d;
      end
   end

   // Next-state: grant, burst counting, release with same-cycle re-grant.
   always_comb begin
      state_d   = state_q;
      gvld_d    = gvld_q;
      gid_d     = gid_q;
      rr_last_d = rr_last_q;
      burst_d   = burst_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               state_d = ARB_GRANT;
               gvld_d  = 1'b1;
               gid_d   = pick_idx;
               burst_d = '0;
            end
         end
         ARB_GRANT: begin
            if (!cur_valid || (xfer_any && (burst_q == CNT_W'(MAX_BURST - 1)))) begin
               rr_last_d = gid_q;
               burst_d   = '0;
               if (pick_found) begin
                  gid_d = pick_idx;
               end else begin
                  state_d = ARB_IDLE;
                  gvld_d  = 1'b0;
               end
            end else if (xfer_any) begin
               burst_d = burst_q + 1'b1;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            gvld_d  = 1'b0;
         end
      endcase
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [STAT_W-1:0] cnt_q [N_REQ];

   // Saturating per-requester transfer counters; clear beats increment.
   always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (stats_clr) begin
               cnt_q[i] <= '0;
            end else if (xfer[i] && (cnt_q[i] != '1)) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Flatten the counters onto the output bus.
   always_comb begin
      word_cnt = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         word_cnt[i*STAT_W +: STAT_W] = cnt_q[i];
      end
   end
`else
   logic unused_xfer;
   assign unused_xfer = ^xfer;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=8).
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 8;

   logic           wclk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           wfull;
   logic           winc;
   logic [W-1:0]   wdata;
   logic           grant_vld;
   logic [1:0]     grant_id;
`ifdef FIFO_WR_ARB_STATS_EN
   logic           stats_clr;
   logic [N*16-1:0] word_cnt;
`endif

   always #5 wclk = ~wclk;

   fifo_wr_arbiter #(
      .N_REQ     (N),
      .WIDTH     (W),
      .MAX_BURST (MB)
   ) dut (
      .wclk      (wclk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wfull     (wfull),
      .winc      (winc),
      .wdata     (wdata),
      .grant_vld (grant_vld),
      .grant_id  (grant_id)
`ifdef FIFO_WR_ARB_STATS_EN
      ,
      .stats_clr (stats_clr),
      .word_cnt  (word_cnt)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;
   int rem [N];
   int seq [N];
   int winc_cnt = 0;
   logic [N-1:0] xfer;

   typedef struct {
      int id;
      int data;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [3:0] valid;
      logic       full;
      logic       exp_vld;
      int         exp_id;
      logic       exp_winc;
      logic [3:0] exp_ready;
   } vec_t;
   vec_t vecs [6];

   function automatic int mkdata(input int i, input int s);
      return i * 64 + (s % 64);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_words(input int id, input int s0, input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.id   = id;
         e.data = mkdata(id, s0 + k);
         sb.push_back(e);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]       = (rem[i] != 0);
         req_data[i*W +: W] = W'(mkdata(i, seq[i]));
      end
   endtask

   // Compare every FIFO write against the scoreboard.
   task automatic monitor();
      exp_t e;
      xfer = req_valid & req_ready;
      chk("winc_vs_xfer", int'(winc), int'(|xfer));
      if (winc) begin
         winc_cnt++;
         chk("winc_while_full", int'(wfull), 0);
         if (sb.size() == 0) begin
            chk("sb_unexpected_write", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            chk("wr_id", int'(grant_id), e.id);
            chk("wr_data", int'(wdata), e.data);
         end
      end
   endtask

   // One clock: monitor mid-cycle, then retire accepted words.
   task automatic cycle();
      @(negedge wclk);
      monitor();
      @(posedge wclk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (xfer[i]) begin
            rem[i]--;
            seq[i]++;
         end
      end
      drive();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wfull = 1'b0;
      for (int i = 0; i < N; i++) begin
         rem[i] = 0;
         seq[i] = 0;
      end
      drive();
`ifdef FIFO_WR_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      repeat (2) @(posedge wclk);
      #1;
      rst_n = 1'b1;
      #1;
      sb.delete();
   endtask

   int c0;

   initial begin
      vecs[0] = '{4'b0100, 1'b0, 1'b1, 2, 1'b1, 4'b0100};
      vecs[1] = '{4'b1111, 1'b0, 1'b1, 0, 1'b1, 4'b0001};
      vecs[2] = '{4'b1000, 1'b0, 1'b1, 3, 1'b1, 4'b1000};
      vecs[3] = '{4'b0110, 1'b0, 1'b1, 1, 1'b1, 4'b0010};
      vecs[4] = '{4'b1010, 1'b1, 1'b1, 1, 1'b0, 4'b0000};
      vecs[5] = '{4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000};

      // Reset state
      do_reset();
      chk("rst_grant_vld", int'(grant_vld), 0);
      chk("rst_grant_id", int'(grant_id), 0);
      chk("rst_winc", int'(winc), 0);
      chk("rst_req_ready", int'(req_ready), 0);

      // First pick after reset for several request patterns
      for (int e = 0; e < 6; e++) begin
         do_reset();
         for (int i = 0; i < N; i++) rem[i] = vecs[e].valid[i] ? 1 : 0;
         wfull = vecs[e].full;
         drive();
         cycle();
         chk("vec_grant_vld", int'(grant_vld), int'(vecs[e].exp_vld));
         chk("vec_grant_id", int'(grant_id), vecs[e].exp_id);
         chk("vec_winc", int'(winc), int'(vecs[e].exp_winc));
         chk("vec_req_ready", int'(req_ready), int'(vecs[e].exp_ready));
         if (vecs[e].exp_winc) chk("vec_wdata", int'(wdata), mkdata(vecs[e].exp_id, 0));
      end

      // Single requester, three words, then release to idle
      do_reset();
      rem[2] = 3;
      drive();
      #1;
      chk("a_idle_first", int'(grant_vld), 0);
      push_words(2, 0, 3);
      cycle();
      chk("a_grant_vld", int'(grant_vld), 1);
      chk("a_grant_id", int'(grant_id), 2);
      chk("a_winc", int'(winc), 1);
      repeat (3) cycle();
      chk("a_hold_no_data", int'(grant_vld), 1);
      chk("a_no_winc", int'(winc), 0);
      cycle();
      chk("a_back_idle", int'(grant_vld), 0);
      chk("a_sb_empty", sb.size(), 0);

      // All requesters busy: 0,1,2,3,0 with 8 words each and no bubbles
      do_reset();
      for (int i = 0; i < N; i++) rem[i] = 100;
      drive();
      for (int i = 0; i < N; i++) push_words(i, 0, MB);
      push_words(0, MB, MB);
      cycle();
      c0 = winc_cnt;
      repeat (40) cycle();
      chk("b_back_to_back", winc_cnt - c0, 40);
      chk("b_sb_empty", sb.size(), 0);
      chk("b_next_grant", int'(grant_id), 1);

      // wfull stall mid-burst does not count toward the burst
      do_reset();
      rem[1] = 20;
      rem[2] = 20;
      drive();
      push_words(1, 0, MB);
      push_words(2, 0, 5);
      cycle();
      c0 = winc_cnt;
      repeat (3) cycle();
      wfull = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("c_stall_winc", int'(winc), 0);
         chk("c_stall_ready", int'(req_ready), 0);
         chk("c_stall_vld", int'(grant_vld), 1);
         chk("c_stall_id", int'(grant_id), 1);
         cycle();
      end
      wfull = 1'b0;
      repeat (10) cycle();
      chk("c_words", winc_cnt - c0, 13);
      chk("c_sb_empty", sb.size(), 0);

      // Sole requester streams 20 words: re-granted without bubbles
      do_reset();
      rem[0] = 20;
      drive();
      push_words(0, 0, 20);
      cycle();
      c0 = winc_cnt;
      repeat (20) cycle();
      chk("d_no_bubble", winc_cnt - c0, 20);
      cycle();
      chk("d_idle", int'(grant_vld), 0);
      chk("d_total", winc_cnt - c0, 20);
      chk("d_sb_empty", sb.size(), 0);

      // Asynchronous reset on the 4th word of requester 3
      do_reset();
      rem[3] = 20;
      drive();
      push_words(3, 0, 3);
      cycle();
      repeat (3) cycle();
      chk("e_pre_winc", int'(winc), 1);
      rst_n = 1'b0;
      #1;
      chk("e_rst_winc", int'(winc), 0);
      chk("e_rst_ready", int'(req_ready), 0);
      chk("e_rst_vld", int'(grant_vld), 0);
      for (int i = 0; i < N; i++) begin
         rem[i] = 5;
         seq[i] = 0;
      end
      drive();
      @(posedge wclk);
      #1;
      rst_n = 1'b1;
      #1;
      cycle();
      chk("e_first_vld", int'(grant_vld), 1);
      chk("e_first_id", int'(grant_id), 0);

`ifdef FIFO_WR_ARB_STATS_EN
      // Saturating counters and clear priority
      do_reset();
      rem[1] = 1;
      drive();
      repeat (70010) @(posedge wclk);
      #1;
      chk("s_sat", int'(word_cnt[16 +: 16]), 16'hFFFF);
      chk("s_other", int'(word_cnt[0 +: 16]), 0);
      stats_clr = 1'b1;
      chk("s_clr_xfer", int'(winc), 1);
      @(posedge wclk);
      #1;
      stats_clr = 1'b0;
      chk("s_clr", int'(word_cnt[16 +: 16]), 0);
      @(posedge wclk);
      #1;
      chk("s_after_clr", int'(word_cnt[16 +: 16]), 1);
`endif

      do_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
